mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the processor's load/store request interface: accepts one request at a time over a valid/ready handshake.
- Holds the access for a configurable number of wait states, then performs the access on a local word array.
- Returns a response over a second valid/ready channel.
- Sits under top as the data-memory end of the core's memory port, replacing the separate memory clock with a single-clock handshake.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >= 4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1, wait states between acceptance and response (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte i (little-endian). Ignored for loads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  1 = misaligned or out-of-range access.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: req_ready=0 while reset is high, 1 in the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, FSM=IDLE, wait counter=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be and set busy=1.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle; when the counter is 0, go to RESP.
- Access commit: happens on the transition into RESP.
  - Error check: err = (addr[1:0]!=0) || addr<BASE_ADDR || addr>=BASE_ADDR+DEPTH_WORDS*4.
  - Error: no array write; rdata=0; err=1.
  - Load: rdata = word[(addr-BASE_ADDR)>>2].
  - Store: write only the bytes whose be bit is 1; rdata=0. A store with be=0 is legal and completes with no change.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready; then go to IDLE.
  - req_ready is 0 throughout RESP; there is no same-cycle request/response overlap.
- Latency:
  - Accept-edge to rsp_valid high = WAIT_CYCLES+1 cycles.
  - Minimum request-to-request spacing = WAIT_CYCLES+2 cycles when rsp_ready is held high.
- Input stability: req_* inputs are sampled only at acceptance; later changes are ignored. req_valid low in IDLE causes no action.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs unchanged.
- Reset mid-operation:
  - A pending access still in WAIT is dropped; a store not yet committed does not write.
  - A store already committed (reset during RESP) remains in the array.
- Word index width: $clog2(DEPTH_WORDS); address bits above the index are used only for the range check.

Decomposition:
- Package mem_pkg: typedef enum logic[1:0] {IDLE, WAIT, RESP} mem_state_t; localparam WORD_W=32; localparam BE_W=4; typedef struct packed {we, addr, wdata, be} mem_req_t.
- Sub-module mem_word_array, instantiated once: DEPTH_WORDS x 32. Per-byte synchronous write enable, asynchronous read of the indexed word, no reset.

Test Plan:
- Reset check: hold reset 2 cycles -> all outputs 0 during reset; req_ready=1 on the first cycle after release.
- Store then load, WAIT_CYCLES=1: store addr 0x10, data 0xDEADBEEF, be=4'hF -> rsp_valid 2 cycles after accept with rdata=0, err=0. Load 0x10 -> rdata=0xDEADBEEF.
- Byte enables: word 0x10 preloaded with 0xDEADBEEF; store 0x10, data 0x11223344, be=4'b0101 -> following load returns 0xDE22BE44.
- Errors: load 0x12 -> err=1, rdata=0. Store 0x400 with DEPTH_WORDS=256 -> err=1, and a later load of 0x0 is unchanged.
- Backpressure and latency sweep:
  - rsp_ready low for 5 cycles -> rsp_valid and data stable all 5 cycles, req_ready=0; one response only.
  - WAIT_CYCLES=0 -> response one cycle after accept.
- Reset mid-operation: WAIT_CYCLES=3; store 0x20, data 0xCAFEF00D; assert reset in the 2nd WAIT cycle -> no response; a later load of 0x20 returns its prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states and the captured request.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with per-byte synchronous write and asynchronous read.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           i_clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [WORD_W-1:0]              i_wdata,
    input  logic [BE_W-1:0]                i_be,
    output logic [WORD_W-1:0]              o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Single-request memory responder: accept, wait WAIT_CYCLES, commit the access
// to the word array on entry to RESP, then hold the response until taken.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mem_state_t        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    mem_req_t          r_req, w_cur;
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_commit;
    logic              w_err;
    logic [ADDR_W:0]   w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [BE_W-1:0]   w_wr_be;
    logic [WORD_W-1:0] w_rd_word;

    assign w_accept = req_valid && req_ready;

    // With zero wait states the commit happens on the accept edge, so the
    // live inputs must be used before they are captured.
    assign w_cur = (r_state == IDLE) ? {req_we, req_addr, req_wdata, req_be} : r_req;

    // Borrow or any bit above the index marks out-of-range; BASE_ADDR is
    // aligned, so the low offset bits are the address alignment bits.
    assign w_off = {1'b0, w_cur.addr} - {1'b0, BASE_ADDR};
    assign w_err = (w_off[1:0] != 2'b00) || (w_off[ADDR_W:IDX_W+2] != '0);
    assign w_idx = w_off[IDX_W+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_commit = !reset && (r_state != RESP) && (w_state_nxt == RESP);
    assign w_wr_be  = (w_commit && w_cur.we && !w_err) ? w_cur.be : '0;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .i_clk   (clk),
        .i_idx   (w_idx),
        .i_wdata (w_cur.wdata),
        .i_be    (w_wr_be),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req <= w_cur;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (!w_err && !w_cur.we) ? w_rd_word : '0;
            end
        end
    end

    assign req_ready = (r_state == IDLE) && !reset;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1, 0, 3) sharing one
// clock, a reference word model and an expected-response queue.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mdl [3][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        mem_responder #(
            .DEPTH_WORDS (256),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_CYCLES (WC)
        ) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    // Called at a negedge with req_ready high; returns at the negedge after accept.
    task automatic send_req(input int k, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input bit commit);
        logic        err;
        logic [31:0] rd;
        logic [31:0] word;
        int          idx;
        err = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        idx = int'(addr[9:2]);
        rd  = 32'h0;
        if (commit) begin
            if (!err && !we) rd = mdl[k][idx];
            if (!err && we) begin
                word = mdl[k][idx];
                for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
                mdl[k][idx] = word;
            end
            exp_q.push_back({err, rd});
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom_range(0, 15));
    endtask

    // Drives one transaction to completion; lat counts negedges from accept to rsp_valid (-1 on timeout).
    task automatic do_txn(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [32:0] got, output logic [32:0] exp, output int lat);
        send_req(k, we, addr, wdata, be, 1'b1);
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) lat = -1;
        got = {rsp_err[k], rsp_rdata[k]};
        if (lat > 0) begin
            rsp_ready[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready[k] = 1'b0;
        end
        exp = exp_q.pop_front();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) reset[k] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({req_ready[k], rsp_valid[k], rsp_err[k], busy[k], rsp_rdata[k]} !== 36'h0) begin
                    errors++;
                    $display("FAIL reset_outputs inst %0d: got rdy=%b vld=%b err=%b busy=%b rdata=%h, want all 0",
                             k, req_ready[k], rsp_valid[k], rsp_err[k], busy[k], rsp_rdata[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({req_ready[k], busy[k], rsp_valid[k]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_release inst %0d: got rdy=%b busy=%b vld=%b, want 1 0 0",
                         k, req_ready[k], busy[k], rsp_valid[k]);
            end
        end
    endtask

    task automatic test_store_load();
        logic [32:0] got, exp;
        int          lat;
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got, exp, lat);
        checks++;
        if (got !== 33'h0 || lat != 2) begin
            errors++;
            $display("FAIL store_0x10: got %h lat %0d, want %h lat 2", got, lat, 33'h0);
        end
        checks++;
        if ({rsp_valid[0], req_ready[0], busy[0]} !== 3'b010) begin
            errors++;
            $display("FAIL after_handshake: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     rsp_valid[0], req_ready[0], busy[0]);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'hDEADBEEF} || got !== exp || lat != 2) begin
            errors++;
            $display("FAIL load_0x10: got %h lat %0d, want %h lat 2", got, lat, {1'b0, 32'hDEADBEEF});
        end
    endtask

    task automatic test_byte_enables();
        logic [32:0] got, exp;
        int          lat;
        do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, got, exp, lat);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL partial_store: got %h, want %h", got, exp);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'hDE22BE44} || got !== exp) begin
            errors++;
            $display("FAIL partial_load: got %h, want %h", got, {1'b0, 32'hDE22BE44});
        end
    endtask

    task automatic test_errors();
        logic [32:0] got, exp;
        int          lat;
        do_txn(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, got, exp, lat);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL preload_0x0: got %h, want %h", got, exp);
        end
        do_txn(0, 1'b0, 32'h12, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b1, 32'h0} || got !== exp) begin
            errors++;
            $display("FAIL misaligned_load: got %h, want %h", got, {1'b1, 32'h0});
        end
        do_txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, got, exp, lat);
        checks++;
        if (got !== {1'b1, 32'h0} || got !== exp) begin
            errors++;
            $display("FAIL range_store: got %h, want %h", got, {1'b1, 32'h0});
        end
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'h5A5A0001} || got !== exp) begin
            errors++;
            $display("FAIL word0_intact: got %h, want %h", got, {1'b0, 32'h5A5A0001});
        end
        do_txn(0, 1'b1, 32'h10, 32'h0BADF00D, 4'h0, got, exp, lat);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'hDE22BE44} || got !== exp) begin
            errors++;
            $display("FAIL be0_store_no_change: got %h, want %h", got, {1'b0, 32'hDE22BE44});
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        int          lat;
        send_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        exp = exp_q.pop_front();
        lat = 1;
        while (!rsp_valid[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]} !== {2'b10, exp}) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: got vld=%b rdy=%b %h, want 1 0 %h",
                         c, rsp_valid[0], req_ready[0], {rsp_err[0], rsp_rdata[0]}, exp);
            end
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_response cycle %0d: got vld=%b, want 0", c, rsp_valid[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait0();
        logic [32:0] got, exp;
        int          lat;
        do_txn(1, 1'b1, 32'h40, 32'h13579BDF, 4'hF, got, exp, lat);
        checks++;
        if (got !== exp || lat != 1) begin
            errors++;
            $display("FAIL wait0_store: got %h lat %0d, want %h lat 1", got, lat, exp);
        end
        do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'h13579BDF} || got !== exp || lat != 1) begin
            errors++;
            $display("FAIL wait0_load: got %h lat %0d, want %h lat 1", got, lat, {1'b0, 32'h13579BDF});
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] got, exp;
        logic [31:0] addr;
        int          lat;
        for (int w = 0; w < 16; w++) begin
            do_txn(0, 1'b1, 32'(w * 4), $urandom, 4'hF, got, exp, lat);
        end
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) addr = 32'h400 + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, 63));
            do_txn(0, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), got, exp, lat);
            checks++;
            if (got !== exp || lat != 2) begin
                errors++;
                $display("FAIL random_txn %0d addr %h: got %h lat %0d, want %h lat 2", n, addr, got, lat, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] got, exp;
        int          lat;
        do_txn(2, 1'b1, 32'h20, 32'h01020304, 4'hF, got, exp, lat);
        checks++;
        if (got !== exp || lat != 4) begin
            errors++;
            $display("FAIL wait3_store: got %h lat %0d, want %h lat 4", got, lat, exp);
        end
        send_req(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
        checks++;
        if ({busy[2], rsp_valid[2], req_ready[2]} !== 3'b100) begin
            errors++;
            $display("FAIL wait3_busy: got busy=%b vld=%b rdy=%b, want 1 0 0", busy[2], rsp_valid[2], req_ready[2]);
        end
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        reset[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({rsp_valid[2], busy[2]} !== 2'b00) begin
                errors++;
                $display("FAIL dropped_no_rsp cycle %0d: got vld=%b busy=%b, want 0 0", c, rsp_valid[2], busy[2]);
            end
            @(negedge clk);
        end
        do_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, got, exp, lat);
        checks++;
        if (got !== {1'b0, 32'h01020304} || got !== exp || lat != 4) begin
            errors++;
            $display("FAIL dropped_store_no_write: got %h lat %0d, want %h lat 4", got, lat, {1'b0, 32'h01020304});
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            reset[k]     = 1'b1;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
            req_be[k]    = 4'h0;
            rsp_ready[k] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_wait0();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
